// File: rtl/seg7_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl_if
//
// CPU-side register bus of the seven-segment scan controller.
//   addr : register select (0 DATA, 1 DP, 2 CTRL, 3 STATUS)
//   we   : write strobe, sampled on the rising clock edge
//   din  : write data
//   dout : read data, combinational from addr
// The master modport is the CPU (or a testbench) and the slave modport is the
// controller.
// ---------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output addr, output we, output din, input dout);
  modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Memory-mapped, time-multiplexed hex display controller. It holds a 32-bit
// value, a decimal-point mask and a control word, and scans DIGITS
// common-electrode digits. All digits share one segment bus, and each digit
// has its own select line.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : register bus (seg7_scan_ctrl_if.slave): addr, we, din, dout
//   seg    : seg[6:0] = g..a and seg[7] = dp, after SEG_ACTIVE_LOW polarity
//   sel    : one-hot digit select, after SEL_ACTIVE_LOW polarity
//
// Register map
//   0 DATA   : 32-bit value. Digit i shows DATA[4i+3:4i].
//   1 DP     : [7:0] per-digit decimal-point mask.
//   2 CTRL   : [0] EN, [1] LZB (leading-zero blanking), [15:8] digit enable,
//              [19:16] BRIGHT (only with SEG7_SCAN_DIM_EN).
//   3 STATUS : [2:0] current scan index. This register is read-only.
//
// Optional build macro
//   SEG7_SCAN_DIM_EN : adds a 4-bit BRIGHT field and a free-running PWM
//                      counter. The PWM gates the select lines to dim the
//                      display.
//
// Parameters
//   DIGITS 1..8, PRESCALE 2..2^20 (clk cycles per digit).
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int DIGITS         = 8,
  parameter int PRESCALE       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       bus,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int                PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0]     PRE_TC   = PW'(PRESCALE - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_OFF  = {DIGITS{SEL_ACTIVE_LOW}};

  // Active-high gfedcba font.
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    case (nib)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  function automatic logic [7:0] seg_pol(input logic [7:0] lit);
    seg_pol = lit ^ {8{SEG_ACTIVE_LOW}};
  endfunction

  function automatic logic [DIGITS-1:0] sel_pol(input logic [DIGITS-1:0] onehot);
    sel_pol = onehot ^ {DIGITS{SEL_ACTIVE_LOW}};
  endfunction

  // Architectural registers
  logic [31:0]       data_q, data_d;
  logic [7:0]        dp_q, dp_d;
  logic              en_q, en_d;
  logic              lzb_q, lzb_d;
  logic [7:0]        dmask_q, dmask_d;
`ifdef SEG7_SCAN_DIM_EN
  logic [3:0]        bright_q, bright_d;
  logic [3:0]        pwm_q, pwm_d;
`endif

  // Scan state
  logic [PW-1:0]     pre_q, pre_d;
  logic [2:0]        idx_q, idx_d;
  logic              tick;

  // Registered display outputs
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] sel_q, sel_d;

  // Display decode
  logic [3:0]        nibble;
  logic              upper_zero;
  logic              blank;
  logic              lit_phase;

  // -------------------------------------------------------------------------
  // Register writes. These never touch the scan state, so a write cannot
  // restart or resynchronise the scan.
  // -------------------------------------------------------------------------
  always_comb begin
    data_d  = data_q;
    dp_d    = dp_q;
    en_d    = en_q;
    lzb_d   = lzb_q;
    dmask_d = dmask_q;
`ifdef SEG7_SCAN_DIM_EN
    bright_d = bright_q;
`endif
    if (bus.we) begin
      case (bus.addr)
        2'd0: data_d = bus.din;
        2'd1: dp_d   = bus.din[7:0];
        2'd2: begin
          en_d    = bus.din[0];
          lzb_d   = bus.din[1];
          dmask_d = bus.din[15:8];
`ifdef SEG7_SCAN_DIM_EN
          bright_d = bus.din[19:16];
`endif
        end
        default: ;  // STATUS is read-only
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler and scan index. Both hold their values while EN is low, so
  // scanning resumes from the same point when EN is set again.
  // -------------------------------------------------------------------------
  assign tick = en_q && (pre_q == PRE_TC);

  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (en_q) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end
    end
  end

`ifdef SEG7_SCAN_DIM_EN
  always_comb begin
    pwm_d = en_q ? pwm_q + 4'd1 : pwm_q;
  end
`endif

  // -------------------------------------------------------------------------
  // Digit decode from the current index. The result is registered, so a tick
  // or a register write shows on the pins one cycle later.
  // -------------------------------------------------------------------------
  assign nibble = data_q[{idx_q, 2'b00} +: 4];

  // The check looks only at nibbles of digits that exist. Digits at or above
  // DIGITS never take part in blanking decisions.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (data_q[4*j +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is exempt from LZB, so a value of zero still shows "0".
  assign blank = !en_q || !dmask_q[idx_q] ||
                 (lzb_q && (idx_q != 3'd0) && upper_zero);

`ifdef SEG7_SCAN_DIM_EN
  assign lit_phase = (pwm_q <= bright_q);
`else
  assign lit_phase = 1'b1;
`endif

  always_comb begin
    seg_d = SEG_OFF;
    sel_d = SEL_OFF;
    if (!blank) begin
      seg_d = seg_pol({dp_q[idx_q], hex_font(nibble)});
      if (lit_phase) begin
        sel_d = sel_pol(DIGITS'(1) << idx_q);
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers. Reset is asynchronous, so the pins go dark as soon as
  // reset is asserted.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      dp_q    <= '0;
      en_q    <= 1'b1;
      lzb_q   <= 1'b0;
      dmask_q <= 8'hFF;
`ifdef SEG7_SCAN_DIM_EN
      bright_q <= 4'hF;
      pwm_q    <= '0;
`endif
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      sel_q   <= SEL_OFF;
    end else begin
      data_q  <= data_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      lzb_q   <= lzb_d;
      dmask_q <= dmask_d;
`ifdef SEG7_SCAN_DIM_EN
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
`endif
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign seg = seg_q;
  assign sel = sel_q;

  // -------------------------------------------------------------------------
  // Read mux
  // -------------------------------------------------------------------------
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      2'd0: bus.dout = data_q;
      2'd1: bus.dout = {24'h0, dp_q};
      2'd2: begin
`ifdef SEG7_SCAN_DIM_EN
        bus.dout = {12'h0, bright_q, dmask_q, 6'h0, lzb_q, en_q};
`else
        bus.dout = {12'h0, 4'h0, dmask_q, 6'h0, lzb_q, en_q};
`endif
      end
      default: bus.dout = {29'h0, idx_q};
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Bench for seg7_scan_ctrl with a scoreboard.
//
// The reference model keeps the register contents and n, the number of clock
// edges seen while EN was set. From n it derives:
//   scan index = (n / PRESCALE) % DIGITS
//   PWM phase  = n % 16
// At every edge the model pushes the expected seg/sel for the next cycle. A
// monitor pops and compares that value on each falling edge. Register reads
// are compared against the model directly.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

  localparam int DIGITS   = 8;
  localparam int PRESCALE = 4;
  localparam bit SEG_AL   = 1'b1;
  localparam bit SEL_AL   = 1'b0;

  typedef struct packed {
    logic [7:0]        seg;
    logic [DIGITS-1:0] sel;
  } exp_t;

  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                       7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                       7'h39, 7'h5E, 7'h79, 7'h71};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        seg;
  logic [DIGITS-1:0] sel;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .DIGITS        (DIGITS),
    .PRESCALE      (PRESCALE),
    .SEG_ACTIVE_LOW(SEG_AL),
    .SEL_ACTIVE_LOW(SEL_AL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .seg  (seg),
    .sel  (sel)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [31:0] m_data   = '0;
  logic [7:0]  m_dp     = '0;
  logic        m_en     = 1'b1;
  logic        m_lzb    = 1'b0;
  logic [7:0]  m_mask   = 8'hFF;
  logic [3:0]  m_bright = 4'hF;
  longint      m_n      = 0;
  exp_t        exp_q[$];

  localparam logic [7:0]        SEG_OFF = {8{SEG_AL}};
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_AL}};

  function automatic int m_idx();
    return int'((m_n / PRESCALE) % DIGITS);
  endfunction

  function automatic exp_t model_out();
    exp_t        e;
    int          idx;
    logic [63:0] upper;
    logic [3:0]  nib;
    logic        blank;
    idx   = m_idx();
    nib   = m_data[4*idx +: 4];
    upper = (64'(m_data) >> (4 * idx)) & ((64'h1 << (4 * (DIGITS - idx))) - 64'h1);
    blank = !m_en || !m_mask[idx] || (m_lzb && idx > 0 && upper == 64'h0);
    e.seg = blank ? 8'h00 : {m_dp[idx], FONT[nib]};
    e.sel = blank ? '0 : (DIGITS'(1) << idx);
`ifdef SEG7_SCAN_DIM_EN
    if (int'(m_n % 16) > int'(m_bright)) e.sel = '0;
`endif
    if (SEG_AL) e.seg = ~e.seg;
    if (SEL_AL) e.sel = ~e.sel;
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return m_data;
      2'd1: return {24'h0, m_dp};
`ifdef SEG7_SCAN_DIM_EN
      2'd2: return {12'h0, m_bright, m_mask, 6'h0, m_lzb, m_en};
`else
      2'd2: return {12'h0, 4'h0, m_mask, 6'h0, m_lzb, m_en};
`endif
      default: return 32'(m_idx());
    endcase
  endfunction

  // Model: advances at every clock edge and resets asynchronously.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_data = '0; m_dp = '0; m_en = 1'b1; m_lzb = 1'b0;
        m_mask = 8'hFF; m_bright = 4'hF; m_n = 0;
        exp_q.delete();
      end else begin
        exp_q.push_back(model_out());
        if (m_en) m_n++;
        if (bus.we) begin
          case (bus.addr)
            2'd0: m_data = bus.din;
            2'd1: m_dp   = bus.din[7:0];
            2'd2: begin
              m_en = bus.din[0]; m_lzb = bus.din[1]; m_mask = bus.din[15:8];
`ifdef SEG7_SCAN_DIM_EN
              m_bright = bus.din[19:16];
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: compares the display pins every cycle.
  always @(negedge clk) begin
    exp_t e;
    vectors++;
    if (reset) begin
      if (seg !== SEG_OFF || sel !== SEL_OFF) begin
        miscompares++;
        $display("FAIL reset_pins: seg=%h sel=%h want seg=%h sel=%h", seg, sel, SEG_OFF, SEL_OFF);
      end
    end else if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_underflow at %0t: seg=%h sel=%h with nothing expected", $time, seg, sel);
    end else begin
      e = exp_q.pop_front();
      if (seg !== e.seg || sel !== e.sel) begin
        miscompares++;
        $display("FAIL pins at %0t: seg=%h sel=%h want seg=%h sel=%h", $time, seg, sel, e.seg, e.sel);
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // One bus cycle: drive the inputs mid-cycle and optionally check the read of addr.
  task automatic step(input logic [1:0] a, input logic w, input logic [31:0] d, input logic chk);
    @(negedge clk); #2;
    bus.addr = a; bus.we = w; bus.din = d;
    #1;
    if (chk) check_val("read", bus.dout, model_read(a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'(i % 4), 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(a, 1'b1, d, 1'b1);
    step(a, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic wait_idx(input int target);
    int k;
    k = 0;
    while (m_idx() != target && k < 200) begin
      step(2'd3, 1'b0, 32'h0, 1'b1);
      k++;
    end
    check_val("wait_idx", 32'(m_idx()), 32'(target));
  endtask

  initial begin
    logic [31:0] r, c;
    int          op;
    bus.addr = 2'd0; bus.we = 1'b0; bus.din = '0;

    // Reset values are visible while reset is held.
    for (int a = 0; a < 4; a++) step(2'(a), 1'b0, 32'h0, 1'b1);
    bus.addr = 2'd2; #1;
`ifdef SEG7_SCAN_DIM_EN
    check_val("ctrl_reset", bus.dout, 32'h000F_FF01);
`else
    check_val("ctrl_reset", bus.dout, 32'h0000_FF01);
`endif
    @(negedge clk); #2; reset = 1'b0;
    idle(6);

    // Full scan of a mixed value.
    wr(2'd0, 32'h1234_ABCD);
    idle(40);

    // Leading-zero blanking.
    wr(2'd2, 32'h0000_FF03);
    wr(2'd0, 32'h0000_00F0);
    idle(36);
    wr(2'd0, 32'h0000_0000);
    idle(36);

    // Decimal points.
    wr(2'd2, 32'h0000_FF01);
    wr(2'd1, 32'hFFFF_FF05);
    wr(2'd0, 32'h8888_8888);
    idle(36);

    // Disable mid-scan at index 3. The index holds, then scanning resumes.
    wait_idx(3);
    wr(2'd2, 32'h0000_FF00);
    idle(10);
    bus.addr = 2'd3; #1;
    check_val("status_hold", bus.dout, 32'(m_idx()));
    wr(2'd3, 32'h0000_0007);   // STATUS write is ignored
    wr(2'd2, 32'h0000_FF01);
    idle(20);

    // Asynchronous reset mid-scan at index 5.
    wait_idx(5);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check_val("async_seg", 32'(seg), 32'(SEG_OFF));
    check_val("async_sel", 32'(sel), 32'(SEL_OFF));
    for (int a = 0; a < 4; a++) step(2'(a), 1'b0, 32'h0, 1'b1);
    @(negedge clk); #2; reset = 1'b0;
    idle(6);

    // BRIGHT field.
    wr(2'd2, 32'h0003_FF01);
    bus.addr = 2'd2; #1;
`ifdef SEG7_SCAN_DIM_EN
    check_val("ctrl_bright", bus.dout, 32'h0003_FF01);
`else
    check_val("ctrl_bright", bus.dout, 32'h0000_FF01);
`endif
    wr(2'd0, 32'hDEAD_BEEF);
    idle(40);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 9));
      r  = $urandom;
      if (op < 3) begin
        r = r >> (4 * $urandom_range(0, 8));
        step(2'd0, 1'b1, r, 1'b1);
      end else if (op == 3) begin
        step(2'd1, 1'b1, r, 1'b1);
      end else if (op == 4) begin
        c = $urandom;
        c[0] = ($urandom_range(0, 3) != 0);
        c[15:8] = c[15:8] | 8'($urandom);
        step(2'd2, 1'b1, c, 1'b1);
      end else if (op == 5) begin
        step(2'd3, 1'b1, r, 1'b1);
      end else begin
        step(2'(op), 1'b0, 32'h0, 1'b1);
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop so the run always ends, even if something hangs.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Bus-mapped, time-multiplexed hex display controller for the MIPS micro-system's memory-mapped I/O space.
- Holds a 32-bit value, a decimal-point mask and a control word in CPU-writable registers.
- Scans DIGITS common-electrode digits at a programmable rate, driving one shared segment bus (a-g, dp) and one select line per digit.
- Adds configurable digit count, polarity, per-digit enable and leading-zero blanking.

Parameters:
- DIGITS, 8, number of digits scanned; legal range 1..8. Digit i shows DATA[4i+3:4i].
- PRESCALE, 50000, clk cycles each digit stays selected; legal range 2..2^20.
- SEG_ACTIVE_LOW, 1, 1 = seg outputs inverted (lit = 0).
- SEL_ACTIVE_LOW, 0, 1 = sel outputs inverted (selected = 0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  2  register select: 0 DATA, 1 DP, 2 CTRL, 3 STATUS.
- we  in  1  write strobe; sampled on the rising clk edge.
- din  in  32  write data.
- dout  out  32  read data; combinational from addr.
- seg  out  8  seg[6:0] = g..a, seg[7] = dp, after SEG_ACTIVE_LOW polarity.
- sel  out  DIGITS  one-hot digit select, after SEL_ACTIVE_LOW polarity.

Behaviour:
- Reset state: DATA = 0, DP = 0, CTRL = 0x0000_FF01, scan index = 0, prescaler = 0.
- During reset, seg and sel are held at their inactive levels.
- Registers:
  - DATA: 32 bits, read/write.
  - DP: bits [7:0] = per-digit decimal-point mask; upper bits read 0.
  - CTRL: bit0 = EN, bit1 = LZB (leading-zero blanking), bits[15:8] = digit enable mask; unused bits read 0.
  - STATUS: read-only; bits[2:0] = current scan index, other bits 0. Writes to STATUS are ignored.
- Register writes land on the clk edge where we = 1. A write never restarts or resynchronises the scan.
- Prescaler:
  - Counts 0..PRESCALE-1 while EN = 1. On terminal count it wraps to 0 and asserts a one-cycle tick.
  - On tick, the index advances; DIGITS-1 wraps to 0.
  - While EN = 0, prescaler and index hold their values.
- Outputs are registered:
  - Every cycle, seg/sel are recomputed from the current index and registers; they update on the next edge.
  - A DATA write is visible on seg 1 cycle after the write edge.
  - The select change follows a tick by 1 cycle.
- Digit i is blanked (sel inactive for all digits, seg inactive) when any of these holds:
  - EN = 0,
  - CTRL[8+i] = 0,
  - LZB = 1 and i > 0 and every nibble j with j >= i is zero.
- Digit 0 is never blanked by LZB, so value 0 displays "0".
- Non-blanked digit: sel = one-hot(index); seg[6:0] = hex font of the nibble; seg[7] = DP[i].
- Hex font, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Nibbles at or above DIGITS are stored and read back but never displayed. CTRL/DP bits for non-existent digits are stored but ignored.
- Simultaneous events:
  - A write on the same edge as a tick: the new register value applies to the newly selected digit.
  - Clearing EN: sel goes inactive 1 cycle later; index is preserved.
  - Setting EN: scanning resumes from the held index and prescaler value.
- Reset asserted mid-scan forces outputs inactive immediately (asynchronously). All state returns to reset values.

Optional Feature:
- Macro: SEG7_SCAN_DIM_EN.
- Defined:
  - CTRL[19:16] = BRIGHT, read/write, reset value 0xF.
  - A free-running 4-bit PWM counter increments every clk while EN = 1.
  - sel for a non-blanked digit is asserted only when pwm_cnt <= BRIGHT. BRIGHT = 15 gives always on; BRIGHT = 0 gives a 1/16 duty cycle.
  - seg is unaffected.
- Undefined: CTRL[19:16] read 0, writes to them are ignored, and sel is asserted for the full digit period.

Test Plan:
1. Reset, then with PRESCALE=4, DIGITS=8, polarities 0, write DATA = 0x1234_ABCD -> seg = 5E with sel = 0x01 for 4 cycles, then seg = 39 with sel = 0x02, ..., then seg = 06 with sel = 0x80, then wrap to sel = 0x01.
2. Write CTRL = 0x0000_FF03, DATA = 0x0000_00F0 -> digit 0 shows 3F, digit 1 shows 71, digits 2-7 have sel inactive. With DATA = 0, only digit 0 shows 3F.
3. Write DP = 0x05 and SEG_ACTIVE_LOW = 1 with DATA = 0x8888_8888 -> digits 0 and 2 drive seg = 0x00, other digits drive seg = 0x80.
4. Write CTRL = 0x0000_FF00 mid-scan at index 3 -> sel inactive next cycle, STATUS reads 3. Write CTRL = 0x0000_FF01 -> scanning resumes at index 3.
5. Assert reset while index = 5 -> sel and seg go inactive immediately; all reads return the reset values, including CTRL = 0x0000_FF01.
6. With SEG7_SCAN_DIM_EN defined, write BRIGHT = 3 -> sel is active 4 of every 16 cycles. Without the macro, a read of CTRL after writing 0x0003_FF01 returns 0x0000_FF01.
